demux14_reg: RTL

Registered 1-to-4 demultiplexer, the inverse of the team's 4:1 mux: one input stream is steered to one of four output channels chosen by the select pair `{s1,s0}`. Each channel has a one-entry holding register with a valid/ready handshake, so a stalled channel blocks only traffic addressed to it. Per-channel wrapping delivery counters support bring-up and debug. The block sits between a single producer and four independent consumers.

---
 rtl/demux14_reg.sv | 100 ++++++++++
 1 files changed

// File: rtl/demux14_reg.sv
// Purpose : registered 1-to-4 demultiplexer. {s1,s0} steers each accepted word into one of four one-entry channel registers.
// Latency : 1 cycle. A word accepted at edge k is valid on its channel after edge k.
// Backpressure: in_ready follows only the selected channel, so a stalled consumer blocks only traffic addressed to it.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_data/in_valid/in_ready producer side; s1,s0 select the target channel
//   oN/oN_valid/oN_ready      consumer side of channel N (N = 0..3)
//   cntN                      words delivered on channel N, wrapping modulo 2^CNTW
module demux14_reg #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic             o0_valid,
    output logic             o1_valid,
    output logic             o2_valid,
    output logic             o3_valid,
    input  logic             o0_ready,
    input  logic             o1_ready,
    input  logic             o2_ready,
    input  logic             o3_ready,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1,
    output logic [CNTW-1:0]  cnt2,
    output logic [CNTW-1:0]  cnt3
);

    logic [WIDTH-1:0] dat_q [4];
    logic [WIDTH-1:0] dat_d [4];
    logic [CNTW-1:0]  cnt_q [4];
    logic [CNTW-1:0]  cnt_d [4];
    logic [3:0]       vld_q;
    logic [3:0]       vld_d;

    logic [1:0] sel;
    logic [3:0] rdy;
    logic [3:0] drain;
    logic [3:0] load;
    logic [3:0] free;
    logic       accept;

    assign sel = {s1, s0};
    assign rdy = {o3_ready, o2_ready, o1_ready, o0_ready};

    always_comb begin
        drain    = vld_q & rdy;
        // A slot being drained this cycle can take a new word on the same edge.
        free     = ~vld_q | rdy;
        in_ready = ~rst & free[sel];
        accept   = in_valid & in_ready;
        load     = '0;
        for (int n = 0; n < 4; n++) begin
            load[n]  = accept && (sel == 2'(n));
            vld_d[n] = load[n] | (vld_q[n] & ~drain[n]);
            dat_d[n] = load[n] ? in_data : dat_q[n];
            cnt_d[n] = drain[n] ? cnt_q[n] + CNTW'(1) : cnt_q[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int n = 0; n < 4; n++) begin
                dat_q[n] <= '0;
                cnt_q[n] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int n = 0; n < 4; n++) begin
                dat_q[n] <= dat_d[n];
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign o0       = dat_q[0];
    assign o1       = dat_q[1];
    assign o2       = dat_q[2];
    assign o3       = dat_q[3];
    assign o0_valid = vld_q[0];
    assign o1_valid = vld_q[1];
    assign o2_valid = vld_q[2];
    assign o3_valid = vld_q[3];
    assign cnt0     = cnt_q[0];
    assign cnt1     = cnt_q[1];
    assign cnt2     = cnt_q[2];
    assign cnt3     = cnt_q[3];

endmodule
